// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: shadow display registers, tear-free
// load handshake, inter-digit blanking and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned DIV            = 2500,
  parameter int unsigned BLANK          = 50,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_lz_en,
  input  logic [4*NUM_DIGITS-1:0] i_data_in,
  input  logic [NUM_DIGITS-1:0]   i_dot_in,
  input  logic                    i_load,
  output logic                    o_load_ack,
  output logic [3:0]              o_bcd,
  output logic                    o_dot,
  output logic [NUM_DIGITS-1:0]   o_digit_sel,
  output logic                    o_frame_start
);

  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] IDX_MSD   = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK - 1);
  localparam logic [CW-1:0] CNT_SLOT  = CW'(DIV - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic [CW-1:0]           r_cnt;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_shadot;
  logic                    r_load_s;
  logic                    r_load_ack;
  logic                    r_frame_start;
  logic [3:0]              r_bcd;
  logic                    r_dot;
  logic [NUM_DIGITS-1:0]   r_digit_sel;

  state_t                  w_state_nx;
  logic [IW-1:0]           w_idx_nx;
  logic [CW-1:0]           w_cnt_nx;
  logic                    w_frame_nx;
  logic                    w_write;
  logic [3:0]              w_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_run;
  logic [3:0]              w_bcd_nx;
  logic                    w_dot_nx;
  logic [NUM_DIGITS-1:0]   w_onehot;

  // Unpack shadow digits and find the leading run of blank-able zero digits.
  always_comb begin
    w_lz  = '0;
    w_run = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      w_dig[i] = r_shadow[4*i +: 4];
    end
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      w_run   = w_run && (w_dig[i] == 4'h0) && !r_shadot[i];
      w_lz[i] = i_lz_en && (i != 0) && w_run;
    end
  end

  // Next-state: slot counter spans blank+show; index walks MSD down to LSD.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt;
    w_frame_nx = 1'b0;
    if (!i_enable) begin
      w_state_nx = S_IDLE;
      w_idx_nx   = IDX_MSD;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nx = S_BLANK;
          w_idx_nx   = IDX_MSD;
          w_cnt_nx   = '0;
          w_frame_nx = 1'b1;
        end
        S_BLANK: begin
          w_cnt_nx = r_cnt + CW'(1);
          if (r_cnt == CNT_BLANK) w_state_nx = S_SHOW;
        end
        S_SHOW: begin
          if (r_cnt == CNT_SLOT) begin
            w_state_nx = S_BLANK;
            w_cnt_nx   = '0;
            if (r_idx == '0) begin
              w_idx_nx   = IDX_MSD;
              w_frame_nx = 1'b1;
            end else begin
              w_idx_nx = r_idx - IW'(1);
            end
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Shadow write only while idle or on the edge into a new frame.
  assign w_write = r_load_s && i_load && ((r_state == S_IDLE) || w_frame_nx);

  // Output decode from the upcoming state so outputs stay registered.
  always_comb begin
    w_bcd_nx = 4'hF;
    w_dot_nx = 1'b0;
    w_onehot = '0;
    if ((w_state_nx == S_SHOW) && !w_lz[w_idx_nx]) begin
      w_bcd_nx           = w_dig[w_idx_nx];
      w_dot_nx           = r_shadot[w_idx_nx];
      w_onehot[w_idx_nx] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= IDX_MSD;
      r_cnt         <= '0;
      r_shadow      <= '1;
      r_shadot      <= '0;
      r_load_s      <= 1'b0;
      r_load_ack    <= 1'b0;
      r_frame_start <= 1'b0;
      r_bcd         <= 4'hF;
      r_dot         <= 1'b0;
      r_digit_sel   <= SEL_OFF;
    end else begin
      r_state       <= w_state_nx;
      r_idx         <= w_idx_nx;
      r_cnt         <= w_cnt_nx;
      if (w_write) begin
        r_shadow <= i_data_in;
        r_shadot <= i_dot_in;
      end
      r_load_s      <= i_load && !w_write;
      r_load_ack    <= w_write;
      r_frame_start <= w_frame_nx;
      r_bcd         <= w_bcd_nx;
      r_dot         <= w_dot_nx;
      r_digit_sel   <= w_onehot ^ SEL_OFF;
    end
  end

  assign o_load_ack    = r_load_ack;
  assign o_bcd         = r_bcd;
  assign o_dot         = r_dot;
  assign o_digit_sel   = r_digit_sel;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic, every cycle
// compared against a frame-position model of the display.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int DV = 10;
  localparam int BL = 2;
  localparam int FR = ND * DV;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        lz_en;
  logic [15:0] data_in;
  logic [3:0]  dot_in;
  logic        load;
  logic        load_ack;
  logic [3:0]  bcd;
  logic        dot;
  logic [3:0]  digit_sel;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;

  // Model: running flag, position inside the frame, displayed value.
  bit       m_run;
  int       m_t;
  logic [3:0] m_dig [ND];
  logic     m_dot [ND];
  int       m_hi;
  bit       m_ack;
  bit       m_fs;
  bit       m_lz;

  seg_scan_ctrl #(
    .NUM_DIGITS(ND), .DIV(DV), .BLANK(BL), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_lz_en(lz_en),
    .i_data_in(data_in), .i_dot_in(dot_in), .i_load(load),
    .o_load_ack(load_ack), .o_bcd(bcd), .o_dot(dot),
    .o_digit_sel(digit_sel), .o_frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_hi = 0; m_ack = 0; m_fs = 0; m_lz = 0;
    for (int j = 0; j < ND; j++) begin
      m_dig[j] = 4'hF;
      m_dot[j] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit was_idle;
    bit wr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    was_idle = !m_run;
    m_fs  = 0;
    m_ack = 0;
    if (!enable) m_run = 0;
    else if (!m_run) begin
      m_run = 1; m_t = 0; m_fs = 1;
    end else begin
      m_t  = (m_t + 1) % FR;
      m_fs = (m_t == 0);
    end
    wr = load && (m_hi > 0) && (was_idle || m_fs);
    if (wr) begin
      for (int j = 0; j < ND; j++) begin
        m_dig[j] = data_in[4*j +: 4];
        m_dot[j] = dot_in[j];
      end
      m_ack = 1;
      m_hi  = 0;
    end else begin
      m_hi = load ? m_hi + 1 : 0;
    end
    m_lz = lz_en;
  endtask

  task automatic check_outputs();
    logic [3:0] eb;
    logic [3:0] es;
    logic       ed;
    int         d;
    bit         sup;
    eb = 4'hF; es = 4'hF; ed = 1'b0;
    if (m_run && (m_t % DV) >= BL) begin
      d   = ND - 1 - m_t / DV;
      sup = 0;
      if (m_lz && d > 0) begin
        sup = 1;
        for (int j = d; j < ND; j++) if (m_dig[j] != 4'h0 || m_dot[j]) sup = 0;
      end
      if (!sup) begin
        eb = m_dig[d]; ed = m_dot[d]; es[d] = 1'b0;
      end
    end
    chk("bcd", 32'(bcd), 32'(eb));
    chk("dot", 32'(dot), 32'(ed));
    chk("digit_sel", 32'(digit_sel), 32'(es));
    chk("load_ack", 32'(load_ack), 32'(m_ack));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic wait_ack(input int budget);
    bit got;
    got = 0;
    for (int k = 0; k < budget && !got; k++) begin
      step();
      if (load_ack) got = 1;
    end
    chk("ack_seen", 32'(got), 32'd1);
  endtask

  task automatic advance_to(input int t);
    int k;
    k = 0;
    while (!(m_run && m_t == t) && k < 100) begin
      step();
      k++;
    end
    chk("reach_slot", 32'(m_run && m_t == t), 32'd1);
  endtask

  task automatic rand_data();
    for (int j = 0; j < ND; j++) data_in[4*j +: 4] = ($urandom % 2) ? 4'h0 : 4'($urandom % 16);
    dot_in = ($urandom % 4 == 0) ? 4'(1 << ($urandom % 4)) : 4'h0;
  endtask

  initial begin
    logic [3:0] exp_bcd [ND];
    logic [3:0] exp_sel [ND];
    int         fs_prev;
    exp_bcd = '{4'h1, 4'h2, 4'h3, 4'h4};
    exp_sel = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    rst_n = 1'b0; enable = 1'b0; lz_en = 1'b0; load = 1'b0;
    data_in = '0; dot_in = '0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();

    // Idle load of 1234, then scan two frames.
    data_in = 16'h1234; dot_in = 4'h0; load = 1'b1;
    step();
    chk("idle_ack_early", 32'(load_ack), 32'd0);
    step();
    chk("idle_ack_lat", 32'(load_ack), 32'd1);
    load = 1'b0;
    step();
    enable = 1'b1;
    step();
    chk("fs_on_enable", 32'(frame_start), 32'd1);
    fs_prev = 0;
    for (int c = 1; c <= 2 * FR; c++) begin
      step();
      if (m_t % DV == 5) begin
        chk("scan_bcd", 32'(bcd), 32'(exp_bcd[m_t / DV]));
        chk("scan_sel", 32'(digit_sel), 32'(exp_sel[m_t / DV]));
      end
      if (frame_start) begin
        chk("fs_period", 32'(c - fs_prev), 32'(FR));
        fs_prev = c;
      end
    end

    // Load during digit 2 acknowledged only at the next frame start.
    advance_to(15);
    data_in = 16'h5678; load = 1'b1;
    wait_ack(100);
    chk("ack_at_fs", 32'(frame_start), 32'd1);
    load = 1'b0;
    advance_to(5);
    chk("new_frame_d3", 32'(bcd), 32'h5);

    // Asynchronous reset during digit 2's slot.
    advance_to(15);
    chk("pre_rst_bcd", 32'(bcd), 32'h6);
    chk("pre_rst_sel", 32'(digit_sel), 32'hB);
    #1;
    enable = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_sel", 32'(digit_sel), 32'hF);
    chk("rst_bcd", 32'(bcd), 32'hF);
    chk("rst_dot", 32'(dot), 32'd0);
    chk("rst_ack", 32'(load_ack), 32'd0);
    #2;
    rst_n = 1'b1;
    model_reset();
    repeat (4) step();

    // Leading-zero suppression of 0050, then with a dot on digit 2.
    lz_en = 1'b1; data_in = 16'h0050; dot_in = 4'b0000; load = 1'b1;
    wait_ack(10);
    load = 1'b0;
    enable = 1'b1;
    advance_to(5);
    chk("lz_d3_sel", 32'(digit_sel), 32'hF);
    advance_to(15);
    chk("lz_d2_bcd", 32'(bcd), 32'hF);
    advance_to(25);
    chk("lz_d1_bcd", 32'(bcd), 32'h5);
    advance_to(35);
    chk("lz_d0_sel", 32'(digit_sel), 32'hE);
    dot_in = 4'b0100; load = 1'b1;
    wait_ack(100);
    load = 1'b0;
    advance_to(15);
    chk("lzdot_d2_dot", 32'(dot), 32'd1);
    chk("lzdot_d2_sel", 32'(digit_sel), 32'hB);
    advance_to(5);
    chk("lzdot_d3_sel", 32'(digit_sel), 32'hF);

    // Enable dropped mid digit 1, then a fresh frame.
    lz_en = 1'b0;
    advance_to(25);
    enable = 1'b0;
    step();
    chk("dis_sel", 32'(digit_sel), 32'hF);
    step();
    enable = 1'b1;
    step();
    chk("reen_fs", 32'(frame_start), 32'd1);
    step();
    step();
    chk("reen_d3_sel", 32'(digit_sel), 32'h7);

    // Hex pass-through and a held LOAD producing a second ack.
    data_in = 16'hA00F; dot_in = 4'h0; load = 1'b1;
    wait_ack(100);
    step();
    wait_ack(100);
    chk("second_ack_fs", 32'(frame_start), 32'd1);
    load = 1'b0;
    advance_to(5);
    chk("hex_d3", 32'(bcd), 32'hA);
    advance_to(15);
    chk("hex_d2", 32'(bcd), 32'h0);
    advance_to(35);
    chk("hex_d0", 32'(bcd), 32'hF);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      if ($urandom % 120 == 0) enable = !enable;
      if ($urandom % 30 == 0) lz_en = 1'($urandom % 2);
      if (!load) begin
        if ($urandom % 15 == 0) begin
          rand_data();
          load = 1'b1;
        end
      end else if (load_ack) begin
        if ($urandom % 4 != 0) load = 1'b0;
      end else if ($urandom % 60 == 0) begin
        load = 1'b0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-cathode/anode 7-segment digits that share one BCD-to-segment decoder. It holds a shadow copy of the display value. Each cycle it presents one digit's BCD code and dot to the shared decoder and drives the matching digit-select line, with an inter-digit blanking interval to prevent ghosting. It also provides a tear-free load handshake and optional leading-zero suppression.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8).
DIV, 2500, clock cycles per digit slot, blanking included (DIV >= BLANK+1).
BLANK, 50, cycles at the start of each slot with all digits off (>= 1).
SEL_ACTIVE_LOW, 1, 1: DIGIT_SEL active-low; 0: active-high.

Ports:
CLK  in  1  system clock, rising edge.
RSTN  in  1  asynchronous active-low reset.
ENABLE  in  1  1 = scan running; 0 = display dark.
LZ_EN  in  1  leading-zero suppression enable.
DATA_IN  in  4*NUM_DIGITS  BCD digits. Digit i is DATA_IN[4i+3:4i]; digit NUM_DIGITS-1 is the most significant.
DOT_IN  in  NUM_DIGITS  dot per digit, same indexing.
LOAD  in  1  level request to latch DATA_IN/DOT_IN.
LOAD_ACK  out  1  one-cycle pulse on the cycle the shadow registers are written.
BCD  out  4  code to the shared decoder.
DOT  out  1  dot to the shared decoder.
DIGIT_SEL  out  NUM_DIGITS  one-hot (per polarity) digit enable.
FRAME_START  out  1  one-cycle pulse on the first cycle of each frame.

Behaviour:
- Clocking and reset: single clock CLK. Reset RSTN is asynchronous, active-low.
- Outputs are Moore: decoded from registered state/index/counter/shadow only. There is no combinational input-to-output path.
- Reset values:
  - state=IDLE, idx=NUM_DIGITS-1, cnt=0.
  - Shadow digits all 4'hF, shadow dots 0.
  - BCD=4'hF, DOT=0, DIGIT_SEL all inactive, LOAD_ACK=0, FRAME_START=0.
- Blank output set: BCD=4'hF, DOT=0, DIGIT_SEL all inactive. The decoder treats 4'hF as all segments off.
- States:
  - IDLE: blank output set.
    - ENABLE=1 -> BLANK with idx=NUM_DIGITS-1, cnt=0, FRAME_START=1 in that first BLANK cycle.
  - BLANK: blank output set; cnt increments.
    - cnt==BLANK-1 -> SHOW.
  - SHOW: BCD=shadow[idx], DOT=shadot[idx], DIGIT_SEL[idx] active, all others inactive; cnt increments.
    - cnt==DIV-1 -> BLANK, cnt=0, and idx decrements.
    - Wrap: idx 0 -> NUM_DIGITS-1, and FRAME_START pulses on that BLANK cycle.
- ENABLE=0 in any state -> IDLE on the next edge; counters reset to the IDLE values. Re-enabling always starts a fresh frame at the MSD.
- Frame period = NUM_DIGITS*DIV cycles. Each digit is lit DIV-BLANK cycles per frame.
- Load handshake:
  - Requester raises LOAD and holds LOAD, DATA_IN and DOT_IN stable until LOAD_ACK is seen.
  - In IDLE, a sampled LOAD=1 writes the shadow on the next edge; LOAD_ACK=1 in the following cycle.
  - While scanning, the write occurs only at the edge that enters a frame start (the FRAME_START cycle), so a frame never mixes old and new values. LOAD_ACK coincides with FRAME_START.
  - LOAD dropped before ack: no write, no ack.
  - LOAD still high in the cycle after LOAD_ACK counts as a new request.
  - The frame that starts with the write shows the new value.
- Leading-zero suppression, evaluated from the shadow registers:
  - Digit i (i>0) is suppressed when LZ_EN=1, all shadow digits i..NUM_DIGITS-1 equal 0, and all shadow dots i..NUM_DIGITS-1 equal 0.
  - A suppressed digit's SHOW slot outputs the blank output set; timing is unchanged.
  - Digit 0 is never suppressed.
- Codes 4'hA..4'hF are passed through unmodified (no range check).
- Reset asserted mid-operation forces all reset values immediately (asynchronously). A pending load is discarded.

Test Plan:
(Bench parameters: NUM_DIGITS=4, DIV=10, BLANK=2, SEL_ACTIVE_LOW=1.)
1. RSTN pulsed low during SHOW of digit 2 -> same-cycle DIGIT_SEL=4'b1111, BCD=4'hF, DOT=0, LOAD_ACK=0; after release, stays IDLE while ENABLE=0.
2. ENABLE=0, DATA_IN=16'h1234, DOT_IN=0, LOAD=1 -> LOAD_ACK pulse 2 cycles after LOAD is raised. Then ENABLE=1 -> FRAME_START pulse; per frame, 2 blank cycles, then 8 cycles each of:
   - BCD=1, DIGIT_SEL=4'b0111
   - BCD=2, DIGIT_SEL=4'b1011
   - BCD=3, DIGIT_SEL=4'b1101
   - BCD=4, DIGIT_SEL=4'b1110
   FRAME_START every 40 cycles.
3. While scanning 16'h1234, LOAD with 16'h5678 during digit 2's SHOW -> no ack until the next FRAME_START cycle; digits 1 and 0 still show 3 and 4; the next frame shows 5,6,7,8.
4. LZ_EN=1, DATA_IN=16'h0050, DOT_IN=4'b0000 -> digits 3 and 2 blank during SHOW (DIGIT_SEL=4'b1111, BCD=4'hF); digit 1 shows 5, digit 0 shows 0. Reload with DOT_IN=4'b0100 -> digit 2 shows BCD=0, DOT=1; digit 3 stays blank.
5. ENABLE dropped at cnt=5 of digit 1 -> blank output set next cycle. ENABLE raised again -> FRAME_START pulse, scan restarts at digit 3 with cnt=0.
6. DATA_IN=16'hA00F with LZ_EN=0 -> BCD outputs A,0,0,F in slot order. LOAD held for 2 cycles past LOAD_ACK -> a second LOAD_ACK at the following frame start.
